// File: rtl/mem_wb_stage.sv
// MEM -> write-back pipeline register: big-endian byte/halfword load extraction,
// misaligned-load detection, stall/flush control and a retired-instruction counter.
module mem_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_load_instr,
    input  logic              in_rf_enable,
    input  logic [1:0]        in_mem_size,
    input  logic              in_mem_se,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_rdata,
    output logic              wb_valid,
    output logic              wb_rf_enable,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_misaligned,
    output logic [CNT_W-1:0]  retired_cnt
);

    logic [1:0]        addr;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_val;
    logic              mis;

    logic              valid_d, valid_q;
    logic              rfen_d, rfen_q;
    logic              mis_d, mis_q;
    logic [REG_AW-1:0] rd_d, rd_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    // Lane 0 is the most significant byte of the returned word.
    always_comb begin
        addr = in_alu_result[1:0];
        unique case (addr)
            2'd0:    byte_sel = in_mem_rdata[31:24];
            2'd1:    byte_sel = in_mem_rdata[23:16];
            2'd2:    byte_sel = in_mem_rdata[15:8];
            default: byte_sel = in_mem_rdata[7:0];
        endcase
        half_sel = addr[1] ? in_mem_rdata[15:0] : in_mem_rdata[31:16];
        unique case (in_mem_size)
            2'b00:   load_val = {{(DATA_W-8){in_mem_se & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{(DATA_W-16){in_mem_se & half_sel[15]}}, half_sel};
            default: load_val = in_mem_rdata;
        endcase
        mis = in_valid & in_load_instr &
              (((in_mem_size == 2'b01) & addr[0]) | (in_mem_size[1] & (addr != 2'b00)));
    end

    always_comb begin
        valid_d = valid_q;
        rfen_d  = rfen_q;
        mis_d   = mis_q;
        rd_d    = rd_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            rfen_d  = 1'b0;
            mis_d   = 1'b0;
            rd_d    = '0;
            data_d  = '0;
        end else if (!stall) begin
            valid_d = in_valid;
            rfen_d  = in_valid & in_rf_enable & ~mis & (in_rd != '0);
            mis_d   = mis;
            rd_d    = in_valid ? in_rd : '0;
            data_d  = in_valid ? (in_load_instr ? load_val : in_alu_result) : '0;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            rfen_q  <= 1'b0;
            mis_q   <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rfen_q  <= rfen_d;
            mis_q   <= mis_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_valid      = valid_q;
    assign wb_rf_enable  = rfen_q;
    assign wb_misaligned = mis_q;
    assign wb_rd         = rd_q;
    assign wb_data       = data_q;
    assign retired_cnt   = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, hand-written stall/flush/reset/wrap
// sequences and randomized traffic against an arithmetic reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        in_valid, in_load_instr, in_rf_enable, in_mem_se;
    logic [1:0]  in_mem_size;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result, in_mem_rdata;

    logic        wb_valid, wb_rf_enable, wb_misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, retired_cnt;

    logic        s_valid, s_rf_enable, s_misaligned;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic [2:0]  s_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        e_valid, e_rfen, e_mis;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_cnt;

    mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_load_instr(in_load_instr), .in_rf_enable(in_rf_enable),
        .in_mem_size(in_mem_size), .in_mem_se(in_mem_se), .in_rd(in_rd),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .wb_valid(wb_valid), .wb_rf_enable(wb_rf_enable), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_misaligned(wb_misaligned), .retired_cnt(retired_cnt)
    );

    // Narrow counter instance makes the wrap-to-zero boundary reachable in a few cycles.
    mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(3)) u_small (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_load_instr(in_load_instr), .in_rf_enable(in_rf_enable),
        .in_mem_size(in_mem_size), .in_mem_se(in_mem_se), .in_rd(in_rd),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .wb_valid(s_valid), .wb_rf_enable(s_rf_enable), .wb_rd(s_rd),
        .wb_data(s_data), .wb_misaligned(s_misaligned), .retired_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        v, ld, rf;
        logic [1:0]  sz;
        logic        se;
        logic [4:0]  rd;
        logic [31:0] alu, rdata;
        logic        ev, erf;
        logic [4:0]  erd;
        logic [31:0] edata;
        logic        emis, einc;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic erf, input logic [4:0] erd,
                             input logic [31:0] edata, input logic emis, input logic [31:0] ecnt);
        check({tag, ".valid"}, 32'(wb_valid), 32'(ev));
        check({tag, ".rf_enable"}, 32'(wb_rf_enable), 32'(erf));
        check({tag, ".rd"}, 32'(wb_rd), 32'(erd));
        check({tag, ".data"}, wb_data, edata);
        check({tag, ".misaligned"}, 32'(wb_misaligned), 32'(emis));
        check({tag, ".retired_cnt"}, retired_cnt, ecnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic ld, input logic rf, input logic [1:0] sz,
                          input logic se, input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] rdata);
        in_valid = v; in_load_instr = ld; in_rf_enable = rf; in_mem_size = sz;
        in_mem_se = se; in_rd = rd; in_alu_result = alu; in_mem_rdata = rdata;
    endtask

    task automatic set_random_in();
        set_in(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
               1'($urandom), 5'($urandom), $urandom, $urandom);
    endtask

    // Reference extraction: shift the addressed big-endian field down, then extend.
    function automatic logic [31:0] ref_extract(input logic [1:0] sz, input logic se,
                                                input logic [31:0] rdata, input int a);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rdata >> (8 * (3 - a))) & 32'h0000_00FF;
            if (se && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rdata >> (16 * (1 - a / 2))) & 32'h0000_FFFF;
            if (se && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    task automatic model_step();
        int  a;
        logic m;
        if (reset) begin
            e_valid = 0; e_rfen = 0; e_mis = 0; e_rd = 0; e_data = 0; e_cnt = 0;
        end else if (flush) begin
            e_valid = 0; e_rfen = 0; e_mis = 0; e_rd = 0; e_data = 0;
        end else if (!stall) begin
            a = int'(in_alu_result[1:0]);
            if (in_mem_size == 2'd1)      m = (a % 2) != 0;
            else if (in_mem_size >= 2'd2) m = (a != 0);
            else                          m = 1'b0;
            m = m && in_valid && in_load_instr;
            e_valid = in_valid;
            e_mis   = m;
            e_rfen  = in_valid && in_rf_enable && !m && (in_rd != 0);
            e_rd    = in_valid ? in_rd : 5'd0;
            e_data  = !in_valid ? 32'd0 :
                      in_load_instr ? ref_extract(in_mem_size, in_mem_se, in_mem_rdata, a) :
                      in_alu_result;
            if (in_valid) e_cnt = e_cnt + 1;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 5'd7,  32'h0000_1001, 32'h1285_3456, 1'b1, 1'b1, 5'd7,  32'hFFFF_FF85, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 5'd7,  32'h0000_1001, 32'h1285_3456, 1'b1, 1'b1, 5'd7,  32'h0000_0085, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 5'd7,  32'h0000_1002, 32'h1234_F00D, 1'b1, 1'b1, 5'd7,  32'hFFFF_F00D, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 5'd7,  32'h0000_1000, 32'h1234_F00D, 1'b1, 1'b1, 5'd7,  32'h0000_1234, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 5'd3,  32'h0000_2002, 32'hCAFE_BABE, 1'b1, 1'b0, 5'd3,  32'hCAFE_BABE, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 5'd0,  32'hDEAD_BEEF, 32'h5555_5555, 1'b1, 1'b0, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 5'd9,  32'hDEAD_BEEF, 32'h5555_5555, 1'b1, 1'b1, 5'd9,  32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 5'd5,  32'h0000_1234, 32'h0000_9999, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 5'd4,  32'h0000_0100, 32'h0000_7777, 1'b1, 1'b0, 5'd4,  32'h0000_0100, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 5'd6,  32'h0000_4000, 32'h89AB_CDEF, 1'b1, 1'b1, 5'd6,  32'h89AB_CDEF, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 5'd6,  32'h0000_4001, 32'h89AB_CDEF, 1'b1, 1'b0, 5'd6,  32'h89AB_CDEF, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 5'd8,  32'h0000_0003, 32'h0000_8001, 1'b1, 1'b0, 5'd8,  32'hFFFF_8001, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 5'd10, 32'h0000_0007, 32'h0000_00FF, 1'b1, 1'b1, 5'd10, 32'hFFFF_FFFF, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 5'd2,  32'h0000_0003, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd2,  32'h0000_0003, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 5'd11, 32'h0000_0000, 32'h80FF_FFFF, 1'b1, 1'b1, 5'd11, 32'h0000_0080, 1'b0, 1'b1};

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        e_cnt = 0;

        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].v, vecs[i].ld, vecs[i].rf, vecs[i].sz, vecs[i].se, vecs[i].rd,
                   vecs[i].alu, vecs[i].rdata);
            tick();
            if (vecs[i].einc) e_cnt = e_cnt + 1;
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erf, vecs[i].erd,
                      vecs[i].edata, vecs[i].emis, e_cnt);
        end

        // Stall for three cycles with changing inputs: everything frozen.
        set_in(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 5'd1, 32'h1111_1111, 32'h0);
        tick();
        e_cnt = e_cnt + 1;
        check_all("pre_stall", 1, 1, 1, 32'h1111_1111, 0, e_cnt);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_random_in();
            in_valid = 1'b1;
            tick();
            check_all($sformatf("stall%0d", i), 1, 1, 1, 32'h1111_1111, 0, e_cnt);
        end

        // Flush wins over stall in the same cycle.
        flush = 1'b1;
        tick();
        check_all("stall_flush", 0, 0, 0, 0, 0, e_cnt);
        stall = 1'b0; flush = 1'b0;

        // Misaligned flag is cleared by a flush.
        set_in(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 5'd3, 32'h0000_0002, 32'h0BAD_F00D);
        tick();
        e_cnt = e_cnt + 1;
        check_all("mis_cap", 1, 0, 3, 32'h0BAD_F00D, 1, e_cnt);
        flush = 1'b1;
        tick();
        check_all("mis_flush", 0, 0, 0, 0, 0, e_cnt);
        flush = 1'b0;

        // Reset during stall with five retired instructions.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 5'(i + 12), 32'(i * 3), 32'h0);
            tick();
        end
        check_all("five", 1, 1, 16, 32'd12, 0, 5);
        stall = 1'b1;
        tick();
        check_all("five_stall", 1, 1, 16, 32'd12, 0, 5);
        reset = 1'b1;
        tick();
        check_all("reset_in_stall", 0, 0, 0, 0, 0, 0);
        reset = 1'b0; stall = 1'b0;

        // Counter wrap on the 3-bit instance.
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0, 32'h0);
            tick();
        end
        check("small_cnt_max", 32'(s_cnt), 32'd7);
        tick();
        check("small_cnt_wrap", 32'(s_cnt), 32'd0);
        check("main_cnt_8", retired_cnt, 32'd8);

        // Randomized traffic against the reference model.
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        model_step();
        tick();
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset = (r < 3);
            flush = (r >= 3 && r < 12);
            stall = ($urandom_range(0, 4) == 0);
            set_random_in();
            if ($urandom_range(0, 7) == 0) in_rd = 5'd0;
            model_step();
            tick();
            check_all($sformatf("rand%0d", i), e_valid, e_rfen, e_rd, e_data, e_mis, e_cnt);
            check($sformatf("rand%0d.small_cnt", i), 32'(s_cnt), {29'd0, e_cnt[2:0]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
